// File: rtl/vreg_load_ctrl.sv
// vreg_load_ctrl: sequences vertical_reg through a convolution tile job.
// Each window gets one enable pulse from ISSUE, a K-cycle feature-buffer
// read burst, a wait for shift_done, and a PRESENT phase that holds
// win_valid until downstream acknowledges. Feature banks ping-pong per window.
//
// Build option: define VREG_CTRL_TIMEOUT_EN to add a WAIT_SHIFT watchdog
// that raises a sticky err and aborts the job after TIMEOUT_CYCLES.
//
// Handshakes:
//   buf_rdy/enable : in ISSUE, enable and the first buf_rd_en beat fire in
//                    the cycle buf_rdy is 1; the remaining K-1 read beats
//                    follow unconditionally.
//   win_valid/consume_done : win_valid rises the cycle after shift_done and
//                    stays high until the cycle consume_done is sampled;
//                    it drops on the following cycle.
module vreg_load_ctrl #(
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           cfg_kn_size_mode,
  input  logic [CNT_WIDTH-1:0] cfg_num_win,
  input  logic                 cfg_shift_mod,
  input  logic                 buf_rdy,
  input  logic                 shift_done,
  input  logic                 consume_done,
  output logic                 enable,
  output logic                 in_select,
  output logic                 shift_mod,
  output logic [1:0]           kn_size_mode,
  output logic                 buf_rd_en,
  output logic                 win_valid,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] win_cnt,
  output logic                 err,
  output logic [2:0]           dbg_state
);

  localparam logic [1:0] KERNEL_SIZE_5_MODE = 2'b00;
  localparam logic [1:0] KERNEL_SIZE_3_MODE = 2'b01;
  localparam logic [1:0] KERNEL_SIZE_1_MODE = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ISSUE      = 3'd1,
    S_WAIT_SHIFT = 3'd2,
    S_PRESENT    = 3'd3,
    S_FINISH     = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic                 in_sel_q, in_sel_d;
  logic [1:0]           mode_q, mode_d;
  logic                 smod_q, smod_d;
  logic [CNT_WIDTH-1:0] num_win_q, num_win_d;
  logic [CNT_WIDTH-1:0] win_cnt_q, win_cnt_d;
  logic [2:0]           burst_q, burst_d;

  logic [2:0]           k_cols;
  logic                 accept;
  logic                 issue_fire;
  logic                 shift_fire;
  logic                 consume_fire;
  logic                 timeout_fire;
  logic [CNT_WIDTH-1:0] win_cnt_inc;
  logic                 last_win;

`ifdef VREG_CTRL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
`endif

  // Column count K per window; the unused code 2'b11 loads like 5_MODE.
  always_comb begin
    k_cols = 3'd5;
    case (mode_q)
      KERNEL_SIZE_5_MODE: k_cols = 3'd5;
      KERNEL_SIZE_3_MODE: k_cols = 3'd3;
      KERNEL_SIZE_1_MODE: k_cols = 3'd1;
      default:            k_cols = 3'd5;
    endcase
  end

  // Qualified events; each is only meaningful in its own state.
  always_comb begin
    accept       = (state_q == S_IDLE) && start;
    issue_fire   = (state_q == S_ISSUE) && buf_rdy;
    shift_fire   = (state_q == S_WAIT_SHIFT) && shift_done;
    consume_fire = (state_q == S_PRESENT) && consume_done;
    win_cnt_inc  = (win_cnt_q == {CNT_WIDTH{1'b1}}) ? win_cnt_q
                                                    : win_cnt_q + CNT_WIDTH'(1);
    last_win     = (win_cnt_inc == num_win_q);
`ifdef VREG_CTRL_TIMEOUT_EN
    timeout_fire = (state_q == S_WAIT_SHIFT) && !shift_done && (wd_q == WD_LAST);
`else
    timeout_fire = 1'b0;
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (cfg_num_win == '0) ? S_FINISH : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (buf_rdy) begin
          state_d = S_WAIT_SHIFT;
        end
      end
      S_WAIT_SHIFT: begin
        if (shift_done) begin
          state_d = S_PRESENT;
        end else if (timeout_fire) begin
          state_d = S_FINISH;
        end
      end
      S_PRESENT: begin
        if (consume_done) begin
          state_d = last_win ? S_FINISH : S_ISSUE;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath next values: job config latch, bank toggle, window count, read burst.
  always_comb begin
    in_sel_d  = in_sel_q;
    mode_d    = mode_q;
    smod_d    = smod_q;
    num_win_d = num_win_q;
    win_cnt_d = win_cnt_q;
    burst_d   = burst_q;
`ifdef VREG_CTRL_TIMEOUT_EN
    wd_d      = wd_q;
    err_d     = err_q;
`endif

    if (accept) begin
      mode_d    = cfg_kn_size_mode;
      smod_d    = cfg_shift_mod;
      num_win_d = cfg_num_win;
      win_cnt_d = '0;
      in_sel_d  = 1'b0;
`ifdef VREG_CTRL_TIMEOUT_EN
      err_d     = 1'b0;
`endif
    end

    // The bank flips only once the loaded window is complete, so the select
    // stays put for the enable cycle and the whole burst.
    if (shift_fire) begin
      in_sel_d = ~in_sel_q;
    end

    if (consume_fire) begin
      win_cnt_d = win_cnt_inc;
    end

    // burst_q counts the read beats still owed after the issue cycle.
    if (issue_fire) begin
      burst_d = k_cols - 3'd1;
    end else if (burst_q != 3'd0) begin
      burst_d = burst_q - 3'd1;
    end

`ifdef VREG_CTRL_TIMEOUT_EN
    if (issue_fire) begin
      wd_d = '0;
    end else if ((state_q == S_WAIT_SHIFT) && (wd_q != WD_LAST)) begin
      wd_d = wd_q + WD_W'(1);
    end
    if (timeout_fire) begin
      err_d = 1'b1;
    end
`endif
  end

  // Datapath registers; reset clears config, count, bank and any open burst.
  always_ff @(posedge clk) begin
    if (!rst) begin
      in_sel_q  <= 1'b0;
      mode_q    <= 2'b00;
      smod_q    <= 1'b0;
      num_win_q <= '0;
      win_cnt_q <= '0;
      burst_q   <= 3'd0;
    end else begin
      in_sel_q  <= in_sel_d;
      mode_q    <= mode_d;
      smod_q    <= smod_d;
      num_win_q <= num_win_d;
      win_cnt_q <= win_cnt_d;
      burst_q   <= burst_d;
    end
  end

`ifdef VREG_CTRL_TIMEOUT_EN
  // Watchdog counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end
`endif

  // Output decode from state and registered datapath.
  always_comb begin
    enable       = issue_fire;
    buf_rd_en    = issue_fire || (burst_q != 3'd0);
    win_valid    = (state_q == S_PRESENT);
    busy         = (state_q != S_IDLE);
    done         = (state_q == S_FINISH);
    in_select    = in_sel_q;
    shift_mod    = smod_q;
    kn_size_mode = mode_q;
    win_cnt      = win_cnt_q;
    dbg_state    = state_q;
`ifdef VREG_CTRL_TIMEOUT_EN
    err          = err_q;
`else
    err          = 1'b0;
`endif
  end

endmodule

// File: tb/tb_vreg_load_ctrl.sv
// Bench for vreg_load_ctrl: directed jobs plus randomized jobs, each checked
// against a schedule model built from the driver's own timing decisions.
module tb_vreg_load_ctrl;

  localparam int CW = 16;
  localparam int TO = 64;
  localparam logic [1:0] M5 = 2'b00;
  localparam logic [1:0] M3 = 2'b01;
  localparam logic [1:0] M1 = 2'b10;
  localparam logic [2:0] ST_IDLE = 3'd0;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic [1:0]    cfg_kn_size_mode = 2'b00;
  logic [CW-1:0] cfg_num_win = '0;
  logic          cfg_shift_mod = 1'b0;
  logic          buf_rdy = 1'b0;
  logic          shift_done = 1'b0;
  logic          consume_done = 1'b0;
  logic          enable, in_select, shift_mod, buf_rd_en, win_valid, busy, done, err;
  logic [1:0]    kn_size_mode;
  logic [CW-1:0] win_cnt;
  logic [2:0]    dbg_state;

  vreg_load_ctrl #(.CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_kn_size_mode(cfg_kn_size_mode), .cfg_num_win(cfg_num_win),
    .cfg_shift_mod(cfg_shift_mod), .buf_rdy(buf_rdy), .shift_done(shift_done),
    .consume_done(consume_done), .enable(enable), .in_select(in_select),
    .shift_mod(shift_mod), .kn_size_mode(kn_size_mode), .buf_rd_en(buf_rd_en),
    .win_valid(win_valid), .busy(busy), .done(done), .win_cnt(win_cnt),
    .err(err), .dbg_state(dbg_state)
  );

  int cmp_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " enable"}, enable, 0);
    check({tag, " in_select"}, in_select, 0);
    check({tag, " shift_mod"}, shift_mod, 0);
    check({tag, " kn_size_mode"}, kn_size_mode, 0);
    check({tag, " buf_rd_en"}, buf_rd_en, 0);
    check({tag, " win_valid"}, win_valid, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " win_cnt"}, win_cnt, 0);
    check({tag, " err"}, err, 0);
    check({tag, " state"}, dbg_state, ST_IDLE);
  endtask

  // One job. The model: windows are issued at the first buf_rdy cycle once
  // the controller is ready (start+1 or ack+1), read for K cycles from the
  // issue, shifted lat cycles after issue, presented from the next cycle
  // until the driver's ack; done follows the last ack (or start for N=0).
  task automatic run_job(input string name, input logic [1:0] mode, input int nwin,
                         input logic smod, input int stall_first, input int rdy_pct,
                         input bit spurious, input int abort_rd, input bit no_shift,
                         input int lat_fix, input int cd_fix);
    int k, accept_cyc, issue_from, en_cyc, sd_at, cd_at, done_cyc;
    int issued, consumed, limit, lat, cdel;
    int bad_en, bad_rd, bad_sel, bad_wv, bad_cnt, bad_cfg, bad_busy, bad_done, bad_err;
    int n_en, n_rd, n_done;
    bit pending, finished, aborted, exp_en, exp_rd, exp_wv, exp_busy, exp_done, exp_err;
    k = (mode == M3) ? 3 : (mode == M1) ? 1 : 5;
    bad_en = 0; bad_rd = 0; bad_sel = 0; bad_wv = 0; bad_cnt = 0; bad_cfg = 0;
    bad_busy = 0; bad_done = 0; bad_err = 0; n_en = 0; n_rd = 0; n_done = 0;
    finished = 0; aborted = 0;
    limit = 400 + nwin * 60;

    tick();
    rst = 1'b1; start = 1'b1; cfg_kn_size_mode = mode; cfg_num_win = CW'(nwin);
    cfg_shift_mod = smod; buf_rdy = 1'b0; shift_done = 1'b0; consume_done = 1'b0;
    accept_cyc = cyc;
    #1;
    en_cyc = -100; sd_at = -100; cd_at = -100; issued = 0; consumed = 0;
    pending = (nwin != 0); issue_from = accept_cyc + 1;
    done_cyc = (nwin == 0) ? accept_cyc + 1 : -1;

    for (int t = 0; t < limit; t++) begin
      tick();
      // drive
      start = 1'b0;
      cfg_kn_size_mode = 2'($urandom_range(3, 0));
      cfg_num_win = CW'($urandom);
      cfg_shift_mod = 1'($urandom_range(1, 0));
      if (pending && cyc >= issue_from && (cyc - issue_from) < stall_first)
        buf_rdy = 1'b0;
      else
        buf_rdy = ($urandom_range(99, 0) < rdy_pct);
      shift_done = !no_shift && (cyc == sd_at);
      consume_done = (cyc == cd_at);
      if (spurious) begin
        if (pending && cyc >= issue_from && !buf_rdy) shift_done = 1'b1;
        if (issued > consumed && cyc == en_cyc + 1) consume_done = 1'b1;
        if (issued > consumed && cyc > sd_at && cyc <= cd_at) start = 1'b1;
      end
      if (abort_rd > 0 && issued == 1 && cyc == en_cyc + abort_rd - 1) rst = 1'b0;
      // sample
      #1;
      if (cd_at >= 0 && cyc == cd_at + 1) consumed++;
      exp_en = pending && cyc >= issue_from && buf_rdy;
      if (enable !== exp_en) bad_en++;
      if (enable === 1'b1) n_en++;
      if (exp_en) begin
        lat  = (lat_fix > 0) ? lat_fix : int'($urandom_range(k + 6, k + 1));
        cdel = (cd_fix >= 0) ? cd_fix : int'($urandom_range(3, 0));
        en_cyc = cyc;
        issued++;
        pending = (issued < nwin);
        if (no_shift) begin
          sd_at = 1 << 30; cd_at = 1 << 30;
          done_cyc = cyc + 1 + TO;
        end else begin
          sd_at = cyc + lat; cd_at = sd_at + 1 + cdel;
          if (issued < nwin) issue_from = cd_at + 1; else done_cyc = cd_at + 1;
        end
      end
      exp_rd = (en_cyc >= 0) && cyc >= en_cyc && cyc <= en_cyc + k - 1;
      if (buf_rd_en !== exp_rd) bad_rd++;
      if (buf_rd_en === 1'b1) n_rd++;
      if (exp_rd && in_select !== 1'(issued - 1)) bad_sel++;
      exp_wv = cyc > sd_at && cyc <= cd_at;
      if (win_valid !== exp_wv) bad_wv++;
      if (win_cnt !== consumed[CW-1:0]) bad_cnt++;
      if (kn_size_mode !== mode || shift_mod !== smod) bad_cfg++;
      exp_busy = cyc > accept_cyc && (done_cyc < 0 || cyc <= done_cyc);
      if (busy !== exp_busy) bad_busy++;
      exp_done = (cyc == done_cyc);
      if (done !== exp_done) bad_done++;
      if (done === 1'b1) n_done++;
      exp_err = no_shift && done_cyc >= 0 && cyc >= done_cyc;
      if (err !== exp_err) bad_err++;
      if (rst == 1'b0) begin aborted = 1; break; end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin finished = 1; break; end
    end

    check({name, " ended"}, finished | aborted, 1);
    check({name, " enable timing"}, bad_en, 0);
    check({name, " buf_rd_en timing"}, bad_rd, 0);
    check({name, " in_select"}, bad_sel, 0);
    check({name, " win_valid timing"}, bad_wv, 0);
    check({name, " win_cnt track"}, bad_cnt, 0);
    check({name, " latched cfg"}, bad_cfg, 0);
    check({name, " busy"}, bad_busy, 0);
    check({name, " done timing"}, bad_done, 0);
    check({name, " err"}, bad_err, 0);
    check({name, " enable count"}, n_en, (abort_rd > 0 || no_shift) ? 1 : nwin);
    check({name, " buf_rd_en count"}, n_rd, (abort_rd > 0) ? abort_rd : (no_shift ? k : nwin * k));
    check({name, " done count"}, n_done, (abort_rd > 0) ? 0 : 1);
    if (finished) check({name, " final win_cnt"}, win_cnt, no_shift ? 0 : nwin);
  endtask

  initial begin
    #2000000;
    $display("FAIL global time limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    // reset state
    rst = 1'b0;
    tick(); tick(); tick();
    #1;
    check_all_zero("reset");

    // K5, three windows, fixed shift latency 8 and ack 2 cycles after win_valid
    run_job("t1_k5", M5, 3, 1'b0, 0, 100, 1'b0, 0, 1'b0, 8, 2);
    // K3, buf_rdy held low 10 cycles in each ISSUE
    run_job("t2_k3_stall", M3, 2, 1'b1, 10, 100, 1'b0, 0, 1'b0, 0, -1);
    // empty job
    run_job("t3_empty", M1, 0, 1'b1, 0, 100, 1'b0, 0, 1'b0, 0, -1);
    // reset during the 3rd read beat of a K5 load (code 2'b11 loads as K5)
    run_job("t4_abort", 2'b11, 2, 1'b1, 0, 100, 1'b0, 3, 1'b0, 7, 1);
    tick();
    rst = 1'b1;
    #1;
    check_all_zero("after_abort");
    run_job("t4_restart", M5, 2, 1'b0, 0, 100, 1'b0, 0, 1'b0, 0, -1);
    // spurious start/shift_done/consume_done in the wrong states
    run_job("t5_spurious", M3, 3, 1'b1, 2, 50, 1'b1, 0, 1'b0, 0, -1);
    // randomized jobs
    for (int j = 0; j < 8; j++) begin
      run_job($sformatf("rnd%0d", j), 2'($urandom_range(3, 0)), int'($urandom_range(5, 1)),
              1'($urandom_range(1, 0)), int'($urandom_range(3, 0)), 70,
              1'($urandom_range(1, 0)), 0, 1'b0, 0, -1);
    end
`ifdef VREG_CTRL_TIMEOUT_EN
    // shift_done never returns: watchdog ends the job, next start clears err
    run_job("t6_timeout", M1, 1, 1'b0, 0, 100, 1'b0, 0, 1'b1, 0, 0);
    run_job("t6_clear", M3, 1, 1'b0, 0, 100, 1'b0, 0, 1'b0, 0, -1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/vreg_load_ctrl.md
Name: vreg_load_ctrl

Overview:
- Sequences `vertical_reg` through one convolution tile job: issues a window-load pulse and ping-pongs between the two input feature banks.
- Waits for `shift_done`, then presents the filled window to the select_array/PE stage until that stage acknowledges consumption.
- Sits between the feature-buffer read logic and `vertical_reg`.
- Counts windows per job and reports completion.

Parameters:
- CNT_WIDTH, 16, width of the window counter and of `cfg_num_win`.
- TIMEOUT_CYCLES, 64, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low (0 = reset), sampled on rising clk.
- start  in  1  one-cycle job start; accepted only in IDLE.
- cfg_kn_size_mode  in  2  kernel mode, codes KERNEL_SIZE_5_MODE / _3_MODE / _1_MODE; latched on start.
- cfg_num_win  in  CNT_WIDTH  windows in the job; latched on start; 0 means an empty job.
- cfg_shift_mod  in  1  shift_mod value for the job; latched on start.
- buf_rdy  in  1  the feature buffer can supply the next window's columns.
- shift_done  in  1  pulse from `vertical_reg` when the window is complete.
- consume_done  in  1  one-cycle ack from downstream that the presented window has been used.
- enable  out  1  load pulse to `vertical_reg`.
- in_select  out  1  bank select to `vertical_reg`: 0 = dia_0, 1 = dia_1.
- shift_mod  out  1  to `vertical_reg`.
- kn_size_mode  out  2  latched mode, to `vertical_reg`.
- buf_rd_en  out  1  feature-buffer column read strobe.
- win_valid  out  1  a complete window is available on doa.
- busy  out  1  job in progress.
- done  out  1  one-cycle job-complete pulse.
- win_cnt  out  CNT_WIDTH  windows consumed so far in the current job.
- err  out  1  sticky timeout flag; constant 0 when the optional feature is compiled out.

Behaviour:
- Reset (rst=0): every output is 0, state = IDLE, in_select = 0, all latched config = 0.
- Column count K per window, from the latched mode:
  - 5 for 5_MODE; 3 for 3_MODE; 1 for 1_MODE.
  - The unused code 2'b11 behaves as 5_MODE.
- FSM states: IDLE, ISSUE, WAIT_SHIFT, PRESENT, FINISH.
- IDLE:
  - On start, latch the config and clear win_cnt.
  - If cfg_num_win == 0, go to FINISH. Otherwise go to ISSUE.
  - start is ignored in every other state.
- ISSUE: waits while buf_rdy = 0. When buf_rdy = 1:
  - enable = 1 for exactly that one cycle.
  - buf_rd_en = 1 for K consecutive cycles starting the same cycle; it is not re-qualified by buf_rdy.
  - Next state is WAIT_SHIFT.
  - Enable only ever rises from ISSUE, so no second enable is issued while the vertical_reg counter is busy.
- in_select:
  - Is stable during the enable cycle and the whole load.
  - Toggles on entry to PRESENT.
  - Windows therefore alternate banks 0,1,0,… starting at 0 for every job.
- WAIT_SHIFT:
  - On shift_done, go to PRESENT with win_valid = 1 the next cycle.
  - A shift_done outside WAIT_SHIFT is ignored.
- PRESENT:
  - win_valid holds at 1 until consume_done, then drops the next cycle.
  - The same edge increments win_cnt.
  - If the new win_cnt == num_win, go to FINISH; otherwise go to ISSUE.
  - A consume_done outside PRESENT is ignored.
- FINISH: done = 1 for one cycle, then IDLE.
- busy = 1 in every state except IDLE; it falls in the cycle after done.
- Minimum window period: 1 (ISSUE) + `vertical_reg` latency + 1 (PRESENT with immediate ack).
- shift_mod and kn_size_mode are driven from the latched values for the whole job and hold their value in IDLE.
- Reset mid-job:
  - Immediately returns to IDLE with all outputs 0.
  - buf_rd_en is cut even mid-burst.
- win_cnt saturates at its maximum width; it cannot wrap within a job because num_win fits in CNT_WIDTH.

Optional Feature:
- Macro: VREG_CTRL_TIMEOUT_EN.
- When defined:
  - A watchdog counter clears on entry to WAIT_SHIFT and increments each cycle spent there.
  - If it reaches TIMEOUT_CYCLES without shift_done, the block sets err = 1 and goes to FINISH, emitting done.
  - err is sticky until reset or the next accepted start.
- When undefined: no watchdog, err is tied to 0, and WAIT_SHIFT waits indefinitely.

Test Plan:
1. Reset, then start with K5 mode, num_win=3, buf_rdy=1, shift_done returned 8 cycles after each enable, and consume_done 2 cycles after each win_valid:
   - 3 enable pulses with in_select 0,1,0.
   - buf_rd_en high for 5 cycles per window.
   - win_cnt steps 1,2,3.
   - done pulses once, then busy=0.
2. K3 mode, num_win=2, with buf_rdy held 0 for 10 cycles in ISSUE:
   - No enable and no buf_rd_en until buf_rdy rises.
   - Then buf_rd_en is high for 3 cycles per window.
   - kn_size_mode output equals the 3_MODE code throughout.
3. start with num_win=0:
   - done one cycle after acceptance.
   - No enable or buf_rd_en pulses; win_cnt = 0.
4. Assert rst=0 during the 3rd buf_rd_en cycle of a K5 load:
   - The next cycle all outputs are 0 and state is IDLE.
   - A fresh start then produces in_select = 0 on its first window.
5. Spurious pulses: start in PRESENT, shift_done in ISSUE, consume_done in WAIT_SHIFT:
   - All are ignored; the sequence and win_cnt are unchanged.
6. (VREG_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=64) Never return shift_done:
   - err = 1 and done pulses at 64 cycles in WAIT_SHIFT.
   - A new start clears err.
